// File: rtl/stone_ram_arbiter_if.sv
// stone_ram_arbiter_if: bundles the two requester ports, the shared read
// return and the RAM port of the stone RAM arbiter.
//
// Handshake: a requester raises *_req with its address, data and we held
// stable. The arbiter answers with *_gnt high for exactly one cycle. A req
// still high in that gnt cycle counts as a new back-to-back request. Dropping
// req before gnt withdraws it with no side effect. Reads come back on
// rd_data qualified by the owner's *_rvalid pulse. There is no back-pressure
// on the read return.
//
// rope_wait is a read-only view of the rope starvation counter.
interface stone_ram_arbiter_if;
    logic        draw_req;
    logic [3:0]  draw_addr;
    logic        draw_gnt;
    logic        draw_rvalid;

    logic        rope_req;
    logic        rope_we;
    logic [3:0]  rope_addr;
    logic [31:0] rope_wdata;
    logic        rope_lock;
    logic        rope_gnt;
    logic        rope_rvalid;

    logic [31:0] rd_data;

    logic [3:0]  ram_address;
    logic [31:0] ram_data;
    logic        ram_wren;
    logic [31:0] ram_q;

    logic [7:0]  rope_wait;

    // Requesters and RAM model side
    modport master (
        output draw_req, draw_addr,
        output rope_req, rope_we, rope_addr, rope_wdata, rope_lock,
        output ram_q,
        input  draw_gnt, draw_rvalid, rope_gnt, rope_rvalid, rd_data,
        input  ram_address, ram_data, ram_wren, rope_wait
    );

    // Arbiter side
    modport slave (
        input  draw_req, draw_addr,
        input  rope_req, rope_we, rope_addr, rope_wdata, rope_lock,
        input  ram_q,
        output draw_gnt, draw_rvalid, rope_gnt, rope_rvalid, rd_data,
        output ram_address, ram_data, ram_wren, rope_wait
    );
endinterface

// File: rtl/stone_ram_arbiter.sv
// stone_ram_arbiter: shares the single-port 16x32 stone RAM between the
// draw engine (read-only, priority) and the rope controller (read/write).
// A starvation counter forces one rope grant after STARVE_LIMIT lost
// arbitrations. Reads return RD_LAT+1 cycles after the grant cycle.
//
// Optional feature macro: STONE_ARB_LOCK_EN. When defined, a rope grant
// with rope_lock = 1 locks out draw until the rope releases the lock.
//
// RD_LAT: 1 or 2. STARVE_LIMIT: 1..255.
module stone_ram_arbiter #(
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 8
) (
    input logic               clock,
    input logic               reset,
    stone_ram_arbiter_if.slave bus
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic              draw_win;
    logic              rope_win;
    logic [7:0]        rope_wait;

    logic              draw_gnt_r;
    logic              rope_gnt_r;
    logic              draw_rvalid_r;
    logic              rope_rvalid_r;
    logic [31:0]       rd_data_r;
    logic [3:0]        ram_address_r;
    logic [31:0]       ram_data_r;
    logic              ram_wren_r;

    // Read-tracking pipeline: valid and owner (1 = rope) per slot
    logic [RD_LAT-1:0] pipe_valid;
    logic [RD_LAT-1:0] pipe_owner;
    logic              rd_push;

`ifdef STONE_ARB_LOCK_EN
    logic              locked;
`else
    logic              unused_rope_lock;
    assign unused_rope_lock = bus.rope_lock;
`endif

    // Pick this cycle's winner from the sampled request lines
    always_comb begin
        draw_win = 1'b0;
        rope_win = 1'b0;
`ifdef STONE_ARB_LOCK_EN
        if (locked) begin
            rope_win = bus.rope_req;
        end else
`endif
        begin
            if (bus.rope_req && rope_wait == LIMIT) begin
                rope_win = 1'b1;
            end else if (bus.draw_req) begin
                draw_win = 1'b1;
            end else if (bus.rope_req) begin
                rope_win = 1'b1;
            end
        end
    end

    // Register grants and load the RAM port from the winner
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            draw_gnt_r    <= 1'b0;
            rope_gnt_r    <= 1'b0;
            ram_wren_r    <= 1'b0;
            ram_address_r <= '0;
            ram_data_r    <= '0;
        end else begin
            draw_gnt_r <= draw_win;
            rope_gnt_r <= rope_win;
            ram_wren_r <= rope_win & bus.rope_we;
            if (draw_win) begin
                ram_address_r <= bus.draw_addr;
            end else if (rope_win) begin
                ram_address_r <= bus.rope_addr;
                ram_data_r    <= bus.rope_wdata;
            end
        end
    end

    // Count rope arbitrations lost to draw, saturating at the limit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rope_wait <= '0;
        end else if (!bus.rope_req || rope_win) begin
            rope_wait <= '0;
        end else if (draw_win && rope_wait != LIMIT) begin
            rope_wait <= rope_wait + 8'd1;
        end
    end

`ifdef STONE_ARB_LOCK_EN
    // Track the rope's atomic read-modify-write lock
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            locked <= 1'b0;
        end else if (rope_win) begin
            locked <= bus.rope_lock;
        end else if (!bus.rope_lock && !bus.rope_req) begin
            locked <= 1'b0;
        end
    end
`endif

    // The grant cycle is the RAM address cycle; a read enters the pipeline then
    assign rd_push = draw_gnt_r | (rope_gnt_r & ~ram_wren_r);

    // Delay read ownership by RD_LAT and return ram_q to its owner on exit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_valid    <= '0;
            pipe_owner    <= '0;
            draw_rvalid_r <= 1'b0;
            rope_rvalid_r <= 1'b0;
            rd_data_r     <= '0;
        end else begin
            pipe_valid[0] <= rd_push;
            pipe_owner[0] <= rope_gnt_r;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_owner[i] <= pipe_owner[i-1];
            end
            draw_rvalid_r <= pipe_valid[RD_LAT-1] & ~pipe_owner[RD_LAT-1];
            rope_rvalid_r <= pipe_valid[RD_LAT-1] &  pipe_owner[RD_LAT-1];
            if (pipe_valid[RD_LAT-1]) begin
                rd_data_r <= bus.ram_q;
            end
        end
    end

    assign bus.draw_gnt    = draw_gnt_r;
    assign bus.rope_gnt    = rope_gnt_r;
    assign bus.draw_rvalid = draw_rvalid_r;
    assign bus.rope_rvalid = rope_rvalid_r;
    assign bus.rd_data     = rd_data_r;
    assign bus.ram_address = ram_address_r;
    assign bus.ram_data    = ram_data_r;
    assign bus.ram_wren    = ram_wren_r;
    assign bus.rope_wait   = rope_wait;

endmodule

// File: tb/tb_stone_ram_arbiter.sv
// tb_stone_ram_arbiter: directed scenarios plus randomized traffic for the
// stone RAM arbiter, with a transaction-level reference model and a
// per-cycle output compare.
module tb_stone_ram_arbiter;

    localparam int RD_LAT       = 1;
    localparam int STARVE_LIMIT = 8;

    logic clock;
    logic reset;

    stone_ram_arbiter_if bus ();

    stone_ram_arbiter #(
        .RD_LAT       (RD_LAT),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- RAM model (read-first, RD_LAT cycles) ----------------
    logic        tb_we;
    logic [3:0]  tb_addr;
    logic [31:0] tb_data;
    logic [31:0] mem    [16];
    logic [31:0] q_pipe [RD_LAT];
    logic [31:0] preload_val [16];

    always @(posedge clock) begin
        q_pipe[0] <= mem[bus.ram_address];
        for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
        if (tb_we) mem[tb_addr] <= tb_data;
        else if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
    end
    assign bus.ram_q = q_pipe[RD_LAT-1];

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pending reads: due cycle, owner (1 = rope), and the data they must carry.
    logic [31:0] exp_q [$];
    int          due_q [$];
    bit          own_q [$];
    logic [31:0] model_mem [16];
    int          cyc = 0;
    int          m_wait = 0;
    bit          m_locked = 0;

    logic        exp_draw_gnt = 0, exp_rope_gnt = 0;
    logic        exp_draw_rvalid = 0, exp_rope_rvalid = 0;
    logic        exp_wren = 0;
    logic [3:0]  exp_addr = 0;
    logic [31:0] exp_wdata = 0;
    logic [31:0] exp_rd_data = 0;

    task automatic model_step();
        bit dw, rw;
        if (tb_we) model_mem[tb_addr] = tb_data;
        if (reset) begin
            exp_q.delete(); due_q.delete(); own_q.delete();
            m_wait = 0; m_locked = 0;
            exp_draw_gnt = 0; exp_rope_gnt = 0;
            exp_draw_rvalid = 0; exp_rope_rvalid = 0;
            exp_wren = 0; exp_addr = 0; exp_wdata = 0; exp_rd_data = 0;
            return;
        end
        cyc++;
        exp_draw_rvalid = 0;
        exp_rope_rvalid = 0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            if (own_q.pop_front()) exp_rope_rvalid = 1; else exp_draw_rvalid = 1;
            exp_rd_data = exp_q.pop_front();
        end
        dw = 0; rw = 0;
`ifdef STONE_ARB_LOCK_EN
        if (m_locked) rw = bus.rope_req;
        else
`endif
        if (bus.rope_req && m_wait >= STARVE_LIMIT) rw = 1;
        else if (bus.draw_req) dw = 1;
        else if (bus.rope_req) rw = 1;

        if (!bus.rope_req || rw) m_wait = 0;
        else if (dw) m_wait = (m_wait + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_wait + 1;
`ifdef STONE_ARB_LOCK_EN
        if (rw) m_locked = bus.rope_lock;
        else if (!bus.rope_lock && !bus.rope_req) m_locked = 0;
`endif
        exp_draw_gnt = dw;
        exp_rope_gnt = rw;
        exp_wren = rw && bus.rope_we;
        if (dw) begin
            exp_addr = bus.draw_addr;
            exp_q.push_back(model_mem[bus.draw_addr]);
            due_q.push_back(cyc + RD_LAT + 1);
            own_q.push_back(0);
        end else if (rw) begin
            exp_addr = bus.rope_addr;
            exp_wdata = bus.rope_wdata;
            if (bus.rope_we) begin
                model_mem[bus.rope_addr] = bus.rope_wdata;
            end else begin
                exp_q.push_back(model_mem[bus.rope_addr]);
                due_q.push_back(cyc + RD_LAT + 1);
                own_q.push_back(1);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or posedge reset);
            model_step();
        end
    end

    // Per-cycle compare, mid-cycle on the falling edge
    initial begin
        forever begin
            @(negedge clock);
            check("draw_gnt",    32'(bus.draw_gnt),    32'(exp_draw_gnt));
            check("rope_gnt",    32'(bus.rope_gnt),    32'(exp_rope_gnt));
            check("draw_rvalid", 32'(bus.draw_rvalid), 32'(exp_draw_rvalid));
            check("rope_rvalid", 32'(bus.rope_rvalid), 32'(exp_rope_rvalid));
            check("rd_data",     bus.rd_data,          exp_rd_data);
            check("ram_wren",    32'(bus.ram_wren),    32'(exp_wren));
            check("ram_address", 32'(bus.ram_address), 32'(exp_addr));
            check("rope_wait",   32'(bus.rope_wait),   32'(m_wait));
            if (exp_wren) check("ram_data", bus.ram_data, exp_wdata);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.draw_req = 0; bus.draw_addr = 0;
        bus.rope_req = 0; bus.rope_we = 0; bus.rope_addr = 0;
        bus.rope_wdata = 0; bus.rope_lock = 0;
    endtask

    task automatic rope_set(input logic we, input logic [3:0] a, input logic [31:0] d, input logic lk);
        bus.rope_req = 1; bus.rope_we = we; bus.rope_addr = a;
        bus.rope_wdata = d; bus.rope_lock = lk;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_draw_gnt"},    32'(bus.draw_gnt), 0);
        check({tag, "_rope_gnt"},    32'(bus.rope_gnt), 0);
        check({tag, "_draw_rvalid"}, 32'(bus.draw_rvalid), 0);
        check({tag, "_rope_rvalid"}, 32'(bus.rope_rvalid), 0);
        check({tag, "_rd_data"},     bus.rd_data, 0);
        check({tag, "_ram_address"}, 32'(bus.ram_address), 0);
        check({tag, "_ram_data"},    bus.ram_data, 0);
        check({tag, "_ram_wren"},    32'(bus.ram_wren), 0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int draw_cnt;
        bit seen;
        reset = 1;
        tb_we = 0; tb_addr = 0; tb_data = 0;
        idle_inputs();

        // Preload RAM while in reset
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            preload_val[i] = (i == 3) ? 32'hDEAD_BEEF : $urandom;
            tb_we = 1; tb_addr = 4'(i); tb_data = preload_val[i];
        end
        @(negedge clock);
        tb_we = 0;
        @(negedge clock);
        check_all_zero("reset");
        #2 reset = 0;

        // Single draw read of addr 3
        @(negedge clock);
        bus.draw_req = 1; bus.draw_addr = 4'd3;
        @(negedge clock);
        check("t1_gnt", 32'(bus.draw_gnt), 1);
        check("t1_addr", 32'(bus.ram_address), 3);
        bus.draw_req = 0;
        @(negedge clock);
        check("t1_early_rvalid", 32'(bus.draw_rvalid), 0);
        @(negedge clock);
        check("t1_rvalid", 32'(bus.draw_rvalid), 1);
        check("t1_data", bus.rd_data, 32'hDEAD_BEEF);
        drain(2);

        // Rope write then back-to-back read of addr 5
        rope_set(1, 4'd5, 32'h0000_1234, 0);
        @(negedge clock);
        check("t2_wgnt", 32'(bus.rope_gnt), 1);
        check("t2_wren", 32'(bus.ram_wren), 1);
        check("t2_waddr", 32'(bus.ram_address), 5);
        check("t2_wdata", bus.ram_data, 32'h0000_1234);
        rope_set(0, 4'd5, 32'h0, 0);
        @(negedge clock);
        check("t2_rgnt", 32'(bus.rope_gnt), 1);
        check("t2_wren_once", 32'(bus.ram_wren), 0);
        bus.rope_req = 0;
        @(negedge clock);
        check("t2_early_rvalid", 32'(bus.rope_rvalid), 0);
        @(negedge clock);
        check("t2_rvalid", 32'(bus.rope_rvalid), 1);
        check("t2_draw_rvalid", 32'(bus.draw_rvalid), 0);
        check("t2_data", bus.rd_data, 32'h0000_1234);
        drain(2);

        // Starvation: draw held, rope held
        bus.draw_req = 1; bus.draw_addr = 4'd6;
        rope_set(0, 4'd9, 32'h0, 0);
        draw_cnt = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (bus.draw_gnt) draw_cnt++;
            if (bus.rope_gnt) begin
                seen = 1;
                bus.rope_req = 0;
            end
        end
        check("t3_rope_seen", 32'(seen), 1);
        check("t3_draw_before_rope", 32'(draw_cnt), STARVE_LIMIT);
        check("t3_wait_cleared", 32'(bus.rope_wait), 0);
        @(negedge clock);
        check("t3_draw_resumes", 32'(bus.draw_gnt), 1);
        bus.draw_req = 0;
        drain(4);

        // Back-to-back draw reads of 0,1,2
        bus.draw_req = 1; bus.draw_addr = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("t4_gnt", 32'(bus.draw_gnt), 1);
            if (i < 2) bus.draw_addr = 4'(i + 1);
            else bus.draw_req = 0;
        end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clock);
            check("t4_rvalid", 32'(bus.draw_rvalid), 1);
            check("t4_data", bus.rd_data, preload_val[i]);
        end
        drain(3);

        // Reset while a rope read is in flight
        rope_set(0, 4'd4, 32'h0, 0);
        @(negedge clock);
        check("t5_gnt", 32'(bus.rope_gnt), 1);
        bus.rope_req = 0;
        @(negedge clock);
        #2 reset = 1;
        @(negedge clock);
        check_all_zero("t5_in_reset");
        #2 reset = 0;
        @(negedge clock);
        check("t5_no_rvalid_a", 32'(bus.rope_rvalid), 0);
        bus.draw_req = 1; bus.draw_addr = 4'd1;
        @(negedge clock);
        check("t5_no_rvalid_b", 32'(bus.rope_rvalid), 0);
        check("t5_regrant", 32'(bus.draw_gnt), 1);
        bus.draw_req = 0;
        drain(4);

`ifdef STONE_ARB_LOCK_EN
        // Locked read-modify-write holds off draw
        rope_set(0, 4'd7, 32'h0, 1);
        @(negedge clock);
        check("t6_lock_gnt", 32'(bus.rope_gnt), 1);
        bus.draw_req = 1; bus.draw_addr = 4'd2;
        rope_set(1, 4'd7, 32'h0000_00A5, 0);
        @(negedge clock);
        check("t6_write_gnt", 32'(bus.rope_gnt), 1);
        check("t6_draw_blocked", 32'(bus.draw_gnt), 0);
        bus.rope_req = 0;
        @(negedge clock);
        check("t6_draw_after", 32'(bus.draw_gnt), 1);
        bus.draw_req = 0;
        drain(4);
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (!bus.draw_req || bus.draw_gnt) begin
                bus.draw_req  = ($urandom_range(0, 99) < 55);
                bus.draw_addr = 4'($urandom_range(0, 15));
            end else if ($urandom_range(0, 99) < 4) begin
                bus.draw_req = 0;
            end
            if (!bus.rope_req || bus.rope_gnt) begin
                bus.rope_req   = ($urandom_range(0, 99) < 50);
                bus.rope_we    = ($urandom_range(0, 99) < 40);
                bus.rope_addr  = 4'($urandom_range(0, 15));
                bus.rope_wdata = $urandom;
                bus.rope_lock  = ($urandom_range(0, 99) < 20);
            end else if ($urandom_range(0, 99) < 4) begin
                bus.rope_req = 0;
            end
        end
        idle_inputs();
        drain(RD_LAT + 6);
        check("final_pending", 32'(due_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stone_ram_arbiter.md
Name: stone_ram_arbiter

Overview:
- Shares the single-port 16x32 stone RAM between two requesters: the stone draw engine (read-only) and the rope controller (read and write, used for hit checks and position saves).
- Replaces the ad-hoc address mux with a registered request/grant handshake.
- Each requester gets a per-read return strobe.
- Draw has priority; a starvation counter guarantees the rope progress.

Parameters:
- RD_LAT, 1: RAM read latency in cycles from the address cycle to valid ram_q. Legal values are 1 and 2.
- STARVE_LIMIT, 8: number of consecutive lost arbitrations after which the rope wins one grant. Legal range is 1..255.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- draw_req  in  1  draw read request; held until draw_gnt.
- draw_addr  in  4  draw read index.
- draw_gnt  out  1  one-cycle grant to draw.
- draw_rvalid  out  1  rd_data valid for draw.
- rope_req  in  1  rope request; held until rope_gnt.
- rope_we  in  1  1 = write, 0 = read.
- rope_addr  in  4  rope index.
- rope_wdata  in  32  rope write data.
- rope_lock  in  1  atomic read-modify-write hint (optional feature only).
- rope_gnt  out  1  one-cycle grant to rope.
- rope_rvalid  out  1  rd_data valid for rope.
- rd_data  out  32  shared read return data.
- ram_address  out  4  RAM address.
- ram_data  out  32  RAM write data.
- ram_wren  out  1  RAM write enable.
- ram_q  in  32  RAM read data.

Behaviour:
- Reset (asynchronous, active-high): all outputs go to 0, including ram_address, ram_data and rd_data. The starvation counter and the read pipeline are cleared. A read in flight when reset asserts produces no rvalid afterwards.
- Arbitration runs every cycle on the sampled req lines. At the next edge the winner's gnt is set for exactly one cycle. In that same edge ram_address, ram_data and ram_wren are loaded from the winner's inputs.
- Minimum request-to-grant latency is 1 cycle. Throughput is one access per cycle.
- A req sampled high during that requester's own gnt cycle is a new, back-to-back request. A requester with no further work must drop req in its gnt cycle.
- When no requester wins: ram_wren = 0 and ram_address holds its last value.
- Priority order:
  - If rope_wait == STARVE_LIMIT, the rope wins.
  - Otherwise, if draw_req is high, draw wins.
  - Otherwise, if rope_req is high, the rope wins.
- rope_wait is an 8-bit counter:
  - +1 each cycle rope_req is high, rope is not being granted, and draw is.
  - Cleared on rope_gnt or when rope_req is low.
  - Saturates at STARVE_LIMIT.
- Reads:
  - A read grant (draw, or rope with rope_we = 0) pushes {valid, owner} into an RD_LAT-deep shift register.
  - On exit from the shift register: rd_data <= ram_q, and the owner's rvalid pulses for 1 cycle.
  - Net latency: rvalid arrives RD_LAT+1 cycles after the gnt cycle.
  - Back-to-back reads return in grant order, one per cycle.
- Writes: rope grant with rope_we = 1 drives ram_wren = 1 for that single cycle only. No rvalid is produced.
- Simultaneous rope write and draw read to the same index, draw winning: the draw sees the old data. The rope write follows in the next eligible cycle.
- A req dropped before grant is withdrawn silently, with no grant and no side effect.
- Address, data and we must stay stable while req is high. Changing them is undefined.

Optional Feature:
- Macro: STONE_ARB_LOCK_EN.
- Defined:
  - A rope grant with rope_lock = 1 sets a locked flag.
  - While locked, draw_req is never granted and the starvation logic is bypassed.
  - Locked clears on a rope grant with rope_lock = 0, or in any cycle where rope_lock = 0 and rope_req = 0.
  - Reset clears locked.
- Undefined: rope_lock is ignored and there is no locked state; arbitration is exactly as above.

Test Plan:
- Reset, then draw_req = 1, draw_addr = 3 with RAM[3] = 0xDEAD_BEEF (RD_LAT = 1) -> draw_gnt 1 cycle after req, ram_address = 3, draw_rvalid 2 cycles after gnt, rd_data = 0xDEAD_BEEF.
- Rope write addr 5, wdata 0x0000_1234, then rope read addr 5 back-to-back -> ram_wren high exactly 1 cycle, rope_rvalid returns 0x0000_1234, draw_rvalid never asserts.
- draw_req held high continuously, rope_req high (STARVE_LIMIT = 8) -> rope_gnt after exactly 8 draw grants, then draw resumes, with rope_wait back at 0.
- Draw reads addr 0,1,2 back-to-back -> draw_gnt high 3 consecutive cycles, three draw_rvalid pulses in order carrying RAM[0], RAM[1], RAM[2].
- Rope read granted, reset pulsed 1 cycle before rvalid is due -> no rope_rvalid, all outputs 0 during reset, normal grant on the first request after release.
- STONE_ARB_LOCK_EN: rope read addr 7 with lock = 1, draw_req high, rope write addr 7 with lock = 0 -> no draw_gnt until the cycle after that rope write's grant.
